// File: rtl/dii_package.sv
// Debug interconnect flit: one 16-bit word plus valid and end-of-packet markers.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_reg_package.sv
// Register-access protocol constants shared by initiators, responders and host bridges.
package osd_reg_package;

    localparam logic [1:0] TYPE_REG             = 2'd0;

    localparam logic [3:0] REQ_READ_16          = 4'd0;
    localparam logic [3:0] REQ_WRITE_16         = 4'd4;

    localparam logic [3:0] RESP_READ_SUCCESS_16 = 4'd0;
    localparam logic [3:0] RESP_READ_ERROR      = 4'd8;
    localparam logic [3:0] RESP_WRITE_SUCCESS   = 4'd12;
    localparam logic [3:0] RESP_WRITE_ERROR     = 4'd13;

    // Header word 2: TYPE[15:14], TYPE_SUB[13:10], remaining bits zero.
    function automatic logic [15:0] reg_hdr(input logic [3:0] sub);
        return {TYPE_REG, sub, 10'd0};
    endfunction

endpackage

// File: rtl/osd_regaccess_initiator.sv
// Register-access initiator: serializes one 16-bit read/write into a DII packet and awaits its response.
// Latency: flit 0 the cycle after acceptance; result the cycle after the response's last flit or at timeout.
// Backpressure: debug_out holds while stalled; debug_in is never stalled; result held until resp_ready.
module osd_regaccess_initiator
    import dii_package::*;
    import osd_reg_package::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_dest,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic [15:0] resp_rdata,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  dii_flit     debug_in,
    output logic        debug_in_ready,
    output logic        stray_pkt
);

    localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, TX, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          wr_q;
    logic [15:0]   dest_q, addr_q, wdata_q;
    logic [2:0]    tx_idx, tx_idx_nxt;
    logic [15:0]   tx_word_nxt;
    logic          tx_last_nxt, tx_accept, tx_done;
    logic [CW-1:0] to_cnt;
    logic          to_fire;
    logic [2:0]    rx_idx;
    logic          rx_ok;
    logic [3:0]    rx_sub_q, rx_sub;
    logic          rx_word_ok, rx_len_ok, rx_match;

    function automatic logic sub_legal(input logic wr, input logic [3:0] sub);
        if (wr)
            return (sub == RESP_WRITE_SUCCESS) || (sub == RESP_WRITE_ERROR);
        return (sub == RESP_READ_SUCCESS_16) || (sub == RESP_READ_ERROR);
    endfunction

    assign tx_accept = debug_out.valid && debug_out_ready;
    assign tx_done   = tx_accept && debug_out.last;
    assign to_fire   = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state; a completion in the expiry cycle takes priority over the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = TX;
            TX:   if (tx_done) state_nxt = WAIT;
            WAIT: if (rx_match || to_fire) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: combinational outputs
    always_comb begin
        req_ready      = (state == IDLE);
        debug_in_ready = 1'b1;
    end

    always_comb begin
        tx_idx_nxt  = tx_idx + 3'd1;
        tx_last_nxt = (tx_idx_nxt == 3'd4) || (!wr_q && (tx_idx_nxt == 3'd3));
        case (tx_idx_nxt)
            3'd1:    tx_word_nxt = id;
            3'd2:    tx_word_nxt = reg_hdr(wr_q ? REQ_WRITE_16 : REQ_READ_16);
            3'd3:    tx_word_nxt = addr_q;
            3'd4:    tx_word_nxt = wdata_q;
            default: tx_word_nxt = dest_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            debug_out <= '0;
            tx_idx    <= '0;
            wr_q      <= 1'b0;
            dest_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (req_valid && req_ready) begin
            wr_q      <= req_write;
            dest_q    <= req_dest;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            tx_idx    <= '0;
            debug_out <= '{valid: 1'b1, last: 1'b0, data: req_dest};
        end else if (tx_done) begin
            debug_out <= '0;
        end else if (tx_accept) begin
            tx_idx    <= tx_idx_nxt;
            debug_out <= '{valid: 1'b1, last: tx_last_nxt, data: tx_word_nxt};
        end
    end

    // Word index 2 carries the subtype live; later words use the captured copy
    always_comb begin
        rx_sub     = (rx_idx == 3'd2) ? debug_in.data[13:10] : rx_sub_q;
        rx_word_ok = 1'b0;
        case (rx_idx)
            3'd0: rx_word_ok = (debug_in.data == id);
            3'd1: rx_word_ok = (debug_in.data == dest_q);
            3'd2: rx_word_ok = (debug_in.data[15:14] == TYPE_REG) &&
                               sub_legal(wr_q, debug_in.data[13:10]);
            3'd3: rx_word_ok = 1'b1;
            default: rx_word_ok = 1'b0;
        endcase
        rx_len_ok = ((rx_idx == 3'd2) && (rx_sub != RESP_READ_SUCCESS_16)) ||
                    ((rx_idx == 3'd3) && (rx_sub == RESP_READ_SUCCESS_16));
        rx_match  = debug_in.valid && debug_in.last && (state == WAIT) &&
                    rx_ok && rx_word_ok && rx_len_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_idx    <= '0;
            rx_ok     <= 1'b1;
            rx_sub_q  <= '0;
            stray_pkt <= 1'b0;
        end else begin
            stray_pkt <= debug_in.valid && debug_in.last && !rx_match;
            if (debug_in.valid) begin
                if (debug_in.last) begin
                    rx_idx <= '0;
                    rx_ok  <= 1'b1;
                end else begin
                    if (rx_idx != 3'd7)
                        rx_idx <= rx_idx + 3'd1;
                    rx_ok <= rx_ok && rx_word_ok && (state == WAIT);
                end
                if (rx_idx == 3'd2)
                    rx_sub_q <= debug_in.data[13:10];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt       <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            if (rx_match) begin
                resp_valid   <= 1'b1;
                resp_err     <= (rx_sub == RESP_READ_ERROR) || (rx_sub == RESP_WRITE_ERROR);
                resp_timeout <= 1'b0;
                resp_rdata   <= (rx_idx == 3'd3) ? debug_in.data : 16'h0000;
            end else if ((state == WAIT) && to_fire) begin
                resp_valid   <= 1'b1;
                resp_err     <= 1'b1;
                resp_timeout <= 1'b1;
                resp_rdata   <= '0;
            end else if (resp_valid && resp_ready) begin
                resp_valid   <= 1'b0;
                resp_err     <= 1'b0;
                resp_timeout <= 1'b0;
                resp_rdata   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_osd_regaccess_initiator.sv
// Directed bench for osd_regaccess_initiator built with a 16-cycle response timeout.
module tb_osd_regaccess_initiator;
    import dii_package::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_dest, req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, resp_timeout;
    logic [15:0] resp_rdata;
    dii_flit     debug_out, debug_in;
    logic        debug_out_ready, debug_in_ready, stray_pkt;

    int tests = 0;
    int fails = 0;

    logic [15:0] txw [0:7];
    int          tx_n, tx_last_pos, tx_cycles, tx_stall_bad;
    logic        tx_acc_ok, tx_first_ok;
    logic        inj_rv_before, inj_stray;

    always #5 clk = ~clk;

    osd_regaccess_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .id(id),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dest(req_dest), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .resp_timeout(resp_timeout), .resp_rdata(resp_rdata),
        .debug_out(debug_out), .debug_out_ready(debug_out_ready),
        .debug_in(debug_in), .debug_in_ready(debug_in_ready), .stray_pkt(stray_pkt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and collect its request flits; stall selects a fixed ready pattern.
    task automatic issue(input logic wr, input logic [15:0] dest, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit stall);
        logic [15:0] pat;
        logic [15:0] held;
        logic        have_held, rdy;
        pat = 16'b0110_1011_0100_1101;
        req_valid = 1'b1; req_write = wr; req_dest = dest; req_addr = addr; req_wdata = wdata;
        tx_acc_ok = (req_ready === 1'b1);
        tick();
        req_valid = 1'b0;
        tx_first_ok = (debug_out.valid === 1'b1);
        tx_n = 0; tx_last_pos = -1; tx_cycles = 0; tx_stall_bad = 0; have_held = 1'b0; held = '0;
        for (int i = 0; i < 60 && tx_last_pos < 0; i++) begin
            rdy = stall ? pat[i % 16] : 1'b1;
            if (have_held && (debug_out.valid !== 1'b1 || debug_out.data !== held))
                tx_stall_bad++;
            debug_out_ready = rdy;
            if (debug_out.valid === 1'b1 && rdy) begin
                if (tx_n < 8) txw[tx_n] = debug_out.data;
                if (debug_out.last === 1'b1) tx_last_pos = tx_n;
                tx_n++;
                have_held = 1'b0;
            end else if (debug_out.valid === 1'b1) begin
                have_held = 1'b1;
                held = debug_out.data;
            end
            tick();
            tx_cycles++;
        end
        debug_out_ready = 1'b1;
    endtask

    task automatic inject(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                          input logic [15:0] w3, input int n);
        logic [15:0] w [0:3];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < n; i++) begin
            debug_in.valid = 1'b1;
            debug_in.last  = (i == n - 1);
            debug_in.data  = w[i];
            if (i == n - 1) inj_rv_before = resp_valid;
            tick();
        end
        debug_in = '0;
        inj_stray = stray_pkt;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; id = 16'h0005; req_valid = 1'b0; req_write = 1'b0;
        req_dest = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        debug_in = '0; debug_out_ready = 1'b1;
        tick(); tick();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tests++; if (debug_out.valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", debug_out.valid); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        tests++; if ({resp_err, resp_timeout} !== 2'b00) begin fails++; $display("FAIL reset_err_to: got %b want 00", {resp_err, resp_timeout}); end
        tests++; if (resp_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", resp_rdata); end
        tests++; if (stray_pkt !== 1'b0) begin fails++; $display("FAIL reset_stray: got %b want 0", stray_pkt); end
        tests++; if (debug_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", debug_in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        issue(1'b0, 16'h0001, 16'h0200, 16'h0000, 1'b0);
        tests++; if (tx_acc_ok !== 1'b1) begin fails++; $display("FAIL read_accept: req_ready low in idle"); end
        tests++; if (tx_first_ok !== 1'b1) begin fails++; $display("FAIL read_first_flit: valid %b want 1 at N+1", debug_out.valid); end
        tests++; if (tx_n != 4 || tx_last_pos != 3) begin fails++; $display("FAIL read_len: got n=%0d last=%0d want 4/3", tx_n, tx_last_pos); end
        tests++; if ({txw[0], txw[1], txw[2], txw[3]} !== 64'h0001_0005_0000_0200) begin fails++;
            $display("FAIL read_flits: got %h %h %h %h want 0001 0005 0000 0200", txw[0], txw[1], txw[2], txw[3]); end
        tests++; if (tx_cycles != 4) begin fails++; $display("FAIL read_tx_cycles: got %0d want 4", tx_cycles); end
        inject(16'h0005, 16'h0001, 16'h0000, 16'hBEEF, 4);
        tests++; if (inj_rv_before !== 1'b0) begin fails++; $display("FAIL read_resp_early: got %b want 0", inj_rv_before); end
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL read_resp_valid: got %b want 1", resp_valid); end
        tests++; if (resp_rdata !== 16'hBEEF) begin fails++; $display("FAIL read_rdata: got %h want beef", resp_rdata); end
        tests++; if ({resp_err, resp_timeout, inj_stray} !== 3'b000) begin fails++; $display("FAIL read_status: got %b want 000", {resp_err, resp_timeout, inj_stray}); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL read_busy: req_ready %b want 0", req_ready); end
        consume();
        tests++; if ({resp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL read_consume: got %b want 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_write();
        issue(1'b1, 16'h0001, 16'h0203, 16'h0003, 1'b0);
        tests++; if (tx_n != 5 || tx_last_pos != 4 || tx_cycles != 5) begin fails++;
            $display("FAIL write_len: got n=%0d last=%0d cyc=%0d want 5/4/5", tx_n, tx_last_pos, tx_cycles); end
        tests++; if ({txw[0], txw[1], txw[2], txw[3], txw[4]} !== 80'h0001_0005_1000_0203_0003) begin fails++;
            $display("FAIL write_flits: got %h %h %h %h %h", txw[0], txw[1], txw[2], txw[3], txw[4]); end
        inject(16'h0005, 16'h0001, 16'h3000, 16'h0000, 3);
        tests++; if ({resp_valid, resp_err, resp_timeout} !== 3'b100 || resp_rdata !== 16'h0000) begin fails++;
            $display("FAIL write_ok: got v/e/t=%b rdata=%h want 100/0000", {resp_valid, resp_err, resp_timeout}, resp_rdata); end
        consume();
        issue(1'b1, 16'h0001, 16'h0203, 16'h0003, 1'b0);
        inject(16'h0005, 16'h0001, 16'h3400, 16'h0000, 3);
        tests++; if ({resp_valid, resp_err, resp_timeout} !== 3'b110) begin fails++;
            $display("FAIL write_err: got %b want 110", {resp_valid, resp_err, resp_timeout}); end
        consume();
    endtask

    task automatic test_read_error();
        issue(1'b0, 16'h0001, 16'h0200, 16'h0000, 1'b0);
        inject(16'h0005, 16'h0001, 16'h2000, 16'h0000, 3);
        tests++; if ({resp_valid, resp_err, resp_timeout} !== 3'b110 || resp_rdata !== 16'h0000) begin fails++;
            $display("FAIL read_err: got v/e/t=%b rdata=%h want 110/0000", {resp_valid, resp_err, resp_timeout}, resp_rdata); end
        consume();
    endtask

    task automatic test_stray_wait();
        issue(1'b0, 16'h0001, 16'h0010, 16'h0000, 1'b0);
        inject(16'h0005, 16'h0009, 16'h0000, 16'h1234, 4);
        tests++; if ({inj_stray, resp_valid} !== 2'b10) begin fails++; $display("FAIL stray_src: stray/valid %b want 10", {inj_stray, resp_valid}); end
        tick();
        tests++; if (stray_pkt !== 1'b0) begin fails++; $display("FAIL stray_pulse: got %b want 0", stray_pkt); end
        inject(16'h0005, 16'h0001, 16'h0000, 16'h0000, 3);
        tests++; if ({inj_stray, resp_valid} !== 2'b10) begin fails++; $display("FAIL stray_len: stray/valid %b want 10", {inj_stray, resp_valid}); end
        inject(16'h0005, 16'h0001, 16'h3000, 16'h0000, 3);
        tests++; if ({inj_stray, resp_valid} !== 2'b10) begin fails++; $display("FAIL stray_sub: stray/valid %b want 10", {inj_stray, resp_valid}); end
        inject(16'h0005, 16'h0001, 16'h0000, 16'hA5A5, 4);
        tests++; if ({inj_stray, resp_valid} !== 2'b01 || resp_rdata !== 16'hA5A5) begin fails++;
            $display("FAIL stray_then_ok: stray/valid %b rdata %h want 01/a5a5", {inj_stray, resp_valid}, resp_rdata); end
        consume();
    endtask

    task automatic test_completion_vs_timeout();
        issue(1'b0, 16'h0001, 16'h0020, 16'h0000, 1'b0);
        repeat (12) tick();
        inject(16'h0005, 16'h0001, 16'h0000, 16'h7E57, 4);
        tests++; if ({resp_valid, resp_err, resp_timeout} !== 3'b100 || resp_rdata !== 16'h7E57) begin fails++;
            $display("FAIL race: got v/e/t=%b rdata=%h want 100/7e57", {resp_valid, resp_err, resp_timeout}, resp_rdata); end
        consume();
    endtask

    task automatic test_timeout();
        int waited, held_bad, rv_bad;
        issue(1'b0, 16'h0001, 16'h0200, 16'h0000, 1'b0);
        waited = -1;
        for (int i = 1; i <= 40 && waited < 0; i++) begin
            tick();
            if (resp_valid === 1'b1) waited = i;
        end
        tests++; if (waited != 16) begin fails++; $display("FAIL timeout_delay: got %0d want 16", waited); end
        tests++; if ({resp_err, resp_timeout} !== 2'b11 || resp_rdata !== 16'h0000) begin fails++;
            $display("FAIL timeout_status: got e/t=%b rdata=%h want 11/0000", {resp_err, resp_timeout}, resp_rdata); end
        held_bad = 0;
        repeat (10) begin
            tick();
            if (resp_valid !== 1'b1 || req_ready !== 1'b0) held_bad++;
        end
        tests++; if (held_bad != 0) begin fails++; $display("FAIL resp_hold: got %0d bad cycles want 0", held_bad); end
        consume();
        inject(16'h0005, 16'h0001, 16'h0000, 16'hBEEF, 4);
        tests++; if ({inj_stray, resp_valid} !== 2'b10) begin fails++; $display("FAIL late_resp: stray/valid %b want 10", {inj_stray, resp_valid}); end
        rv_bad = 0;
        repeat (3) begin
            tick();
            if (resp_valid !== 1'b0) rv_bad++;
        end
        tests++; if (rv_bad != 0) begin fails++; $display("FAIL late_no_resp: got %0d valid cycles want 0", rv_bad); end
    endtask

    task automatic test_backpressure();
        issue(1'b1, 16'h0001, 16'h0203, 16'h0003, 1'b1);
        tests++; if ({txw[0], txw[1], txw[2], txw[3], txw[4]} !== 80'h0001_0005_1000_0203_0003 || tx_last_pos != 4) begin fails++;
            $display("FAIL bp_flits: got %h %h %h %h %h last=%0d", txw[0], txw[1], txw[2], txw[3], txw[4], tx_last_pos); end
        tests++; if (tx_stall_bad != 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", tx_stall_bad); end
        tests++; if (tx_cycles <= 5) begin fails++; $display("FAIL bp_stalled: got %0d cycles want >5", tx_cycles); end
        inject(16'h0005, 16'h0001, 16'h3000, 16'h0000, 3);
        tests++; if ({resp_valid, resp_err} !== 2'b10) begin fails++; $display("FAIL bp_resp: got %b want 10", {resp_valid, resp_err}); end
        consume();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_dest = 16'h0001; req_addr = 16'h0200;
        debug_out_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tests++; if (debug_out.valid !== 1'b1) begin fails++; $display("FAIL midtx_stalled: got %b want 1", debug_out.valid); end
        rst = 1'b1;
        tick();
        tests++; if ({debug_out.valid, req_ready} !== 2'b01) begin fails++; $display("FAIL midtx_reset: valid/rdy %b want 01", {debug_out.valid, req_ready}); end
        rst = 1'b0; debug_out_ready = 1'b1;
        tick();
        issue(1'b0, 16'h0001, 16'h0200, 16'h0000, 1'b0);
        debug_in = '{valid: 1'b1, last: 1'b0, data: 16'h0005};
        tick();
        debug_in = '{valid: 1'b1, last: 1'b0, data: 16'h0001};
        tick();
        debug_in = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        inject(16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 2);
        tests++; if ({inj_stray, resp_valid, req_ready} !== 3'b101) begin fails++;
            $display("FAIL midwait_reset: stray/valid/rdy %b want 101", {inj_stray, resp_valid, req_ready}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read_error();
        test_stray_wait();
        test_completion_vs_timeout();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
